// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an ARRAY_SIZE x ARRAY_SIZE weight-stationary systolic tile: load -> flush -> capture -> drain.
// Optional busy-cycle counter output perf_cycles when SYS_CTRL_PERF_EN is defined.
module systolic_seq_ctrl #(
  parameter int ARRAY_SIZE   = 8,
  parameter int FLUSH_CYCLES = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          arr_enable,
  output logic                          arr_in_write,
  output logic [$clog2(ARRAY_SIZE)-1:0] arr_row_ptr,
  output logic                          arr_out_write,
  output logic                          arr_out_read,
`ifdef SYS_CTRL_PERF_EN
  output logic [31:0]                   perf_cycles,
`endif
  output logic [2:0]                    dbg_state
);

  localparam int CW = $clog2(ARRAY_SIZE);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(ARRAY_SIZE - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_FLUSH   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [FW-1:0] r_fcnt, w_fcnt_nxt;

  // Handshakes: a row moves on a cycle where valid and ready are both high; the
  // tile strobes for that row are asserted combinationally in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_fcnt_nxt    = r_fcnt;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    done          = 1'b0;
    arr_enable    = 1'b0;
    arr_in_write  = 1'b0;
    arr_out_write = 1'b0;
    arr_out_read  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        in_ready     = 1'b1;
        arr_in_write = in_valid;
        arr_enable   = in_valid;
        if (in_valid) begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_FLUSH;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        arr_enable = 1'b1;
        if (r_fcnt == FCNT_LAST) begin
          w_fcnt_nxt  = '0;
          w_state_nxt = S_CAPTURE;
        end else begin
          w_fcnt_nxt = r_fcnt + FW'(1);
        end
      end
      S_CAPTURE: begin
        arr_enable    = 1'b1;
        arr_out_write = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        out_valid    = 1'b1;
        arr_out_read = out_ready;
        arr_enable   = out_ready;
        if (out_ready) begin
          if (r_cnt == CNT_LAST) begin
            done        = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_fcnt_nxt  = '0;
      end
    endcase
  end

  // cnt returns to 0 on every state exit, so the row pointer idles at 0.
  assign arr_row_ptr = r_cnt;
  assign busy        = (r_state != S_IDLE);
  assign dbg_state   = r_state;

`ifdef SYS_CTRL_PERF_EN
  logic [31:0] r_perf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_perf <= '0;
    end else if (busy && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end
  assign perf_cycles = r_perf;
`endif

endmodule
